// File: rtl/bounce_pkg.sv
// Shared constants and FSM state type for the bouncing-ball sprite engine.
// BOUNCE_SPRITES_COLLIDE_EN adds the COLLIDE state used for ball-to-ball collisions.
package bounce_pkg;

  localparam logic [5:0] COLOR_HEART = 6'b11_00_00;
  localparam logic [5:0] COLOR_RING  = 6'b10_00_00;

  localparam logic [7:0] GLOW_INIT = 8'd10;
  localparam logic [7:0] GLOW_HIT  = 8'd200;
  localparam logic [7:0] GLOW_MIN  = 8'd15;
  localparam logic [7:0] GLOW_STEP = 8'd10;

  localparam logic [7:0] VY_BASE = 8'd17;

`ifdef BOUNCE_SPRITES_COLLIDE_EN
  typedef enum logic [1:0] {IDLE, UPDATE, COLLIDE} state_t;
`else
  typedef enum logic [1:0] {IDLE, UPDATE} state_t;
`endif

endpackage

// File: rtl/ball_render.sv
// Per-ball pixel classifier: bounding box, squared distance to centre,
// and heart/ring membership for one ball at the current (h,v).
module ball_render
  import bounce_pkg::*;
#(
  parameter int RADIUS   = 16,
  parameter int GROUND_Y = 384
) (
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic [9:0] x,
  input  logic [9:0] alt,
  input  logic [7:0] glow,
  output logic       heart,
  output logic       ring
);

  localparam logic [12:0] RING_LIM = 13'(RADIUS * RADIUS - 15);

  logic        in_box;
  logic [11:0] y_bot;
  logic [5:0]  dxp, dyp, adx, ady;
  logic [12:0] d2;

  always_comb begin
    y_bot  = 12'(GROUND_Y) - {2'b00, alt};
    in_box = (h >= x) && ({1'b0, h} < {1'b0, x} + 11'(2 * RADIUS)) &&
             ({2'b00, v} < y_bot) && ({2'b00, v} + 12'(2 * RADIUS) >= y_bot);
    // Offsets are only meaningful inside the box, where they fit in 6 signed bits.
    dxp    = 6'(h - x - 10'(RADIUS));
    dyp    = 6'(v + alt + 10'(RADIUS) - 10'(GROUND_Y));
    adx    = dxp[5] ? (6'd0 - dxp) : dxp;
    ady    = dyp[5] ? (6'd0 - dyp) : dyp;
    d2     = 13'(adx) * 13'(adx) + 13'(ady) * 13'(ady);
    heart  = in_box && (d2 < {5'd0, glow});
    ring   = in_box && (d2 < RING_LIM);
  end

endmodule

// File: rtl/bounce_sprites.sv
// Bouncing-ball sprite engine: per-frame physics update plus per-pixel rendering.
// Define BOUNCE_SPRITES_COLLIDE_EN to enable the pairwise ball collision scan.
module bounce_sprites
  import bounce_pkg::*;
#(
  parameter int NUM_BALLS = 3,
  parameter int RADIUS    = 16,
  parameter int GROUND_Y  = 384,
  parameter int FIELD_W   = 640,
  parameter int SPEED_X   = 2,
  parameter int INIT_VEL  = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic       frame_end,
  output logic [5:0] rgb,
  output logic       hit,
  output logic       busy,
  output logic       bounce_pulse
);

  localparam int            IW    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IW-1:0] LAST  = IW'(NUM_BALLS - 1);
  localparam logic [10:0]   X_LIM = 11'(FIELD_W - 2 * RADIUS);
  localparam logic [10:0]   X_SPD = 11'(SPEED_X);

  logic [9:0]        x_reg    [NUM_BALLS];
  logic [9:0]        alt_reg  [NUM_BALLS];
  logic signed [7:0] vy_reg   [NUM_BALLS];
  logic              dir_reg  [NUM_BALLS];
  logic [7:0]        glow_reg [NUM_BALLS];

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          acc_reg;

`ifdef BOUNCE_SPRITES_COLLIDE_EN
  logic [IW-1:0] pi_reg, pi_next, pj_reg, pj_next;
  logic          pair_last, pair_hit;
  logic [9:0]    dx_pair, da_pair;

  always_comb begin
    pair_last = (pj_reg == LAST) && (pi_reg == IW'(NUM_BALLS - 2));
    dx_pair   = (x_reg[pi_reg] > x_reg[pj_reg]) ? x_reg[pi_reg] - x_reg[pj_reg]
                                                : x_reg[pj_reg] - x_reg[pi_reg];
    da_pair   = (alt_reg[pi_reg] > alt_reg[pj_reg]) ? alt_reg[pi_reg] - alt_reg[pj_reg]
                                                    : alt_reg[pj_reg] - alt_reg[pi_reg];
    pair_hit  = (dx_pair < 10'(2 * RADIUS)) && (da_pair < 10'(2 * RADIUS)) &&
                (dir_reg[pi_reg] != dir_reg[pj_reg]);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
`ifdef BOUNCE_SPRITES_COLLIDE_EN
      pi_reg    <= '0;
      pj_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
`ifdef BOUNCE_SPRITES_COLLIDE_EN
      pi_reg    <= pi_next;
      pj_reg    <= pj_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
`ifdef BOUNCE_SPRITES_COLLIDE_EN
    pi_next    = pi_reg;
    pj_next    = pj_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (frame_end) begin
          state_next = UPDATE;
          idx_next   = '0;
        end
      end
      UPDATE: begin
        if (idx_reg == LAST) begin
`ifdef BOUNCE_SPRITES_COLLIDE_EN
          state_next = (NUM_BALLS > 1) ? COLLIDE : IDLE;
          pi_next    = '0;
          pj_next    = IW'(1);
`else
          state_next = IDLE;
`endif
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
`ifdef BOUNCE_SPRITES_COLLIDE_EN
      COLLIDE: begin
        if (pair_last) begin
          state_next = IDLE;
        end else if (pj_reg == LAST) begin
          pi_next = pi_reg + 1'b1;
          pj_next = pi_reg + IW'(2);
        end else begin
          pj_next = pj_reg + 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  logic [9:0]        cur_x, cur_alt, nx, nalt;
  logic signed [7:0] cur_vy, nvy;
  logic              cur_dir, ndir, ground, edge_hit;
  logic [7:0]        cur_glow, nglow;
  logic [8:0]        neg_vy;
  logic [10:0]       x_sum;

  always_comb begin
    cur_x    = x_reg[idx_reg];
    cur_alt  = alt_reg[idx_reg];
    cur_vy   = vy_reg[idx_reg];
    cur_dir  = dir_reg[idx_reg];
    cur_glow = glow_reg[idx_reg];

    // Bounce velocity is seeded from the pre-update x so balls desynchronise.
    neg_vy = 9'd0 - {cur_vy[7], cur_vy};
    ground = cur_vy[7] && ({1'b0, cur_alt} <= {2'b00, neg_vy});
    if (ground) begin
      nalt = '0;
      nvy  = VY_BASE + {5'd0, cur_x[2:0]};
    end else begin
      nalt = cur_alt + {{2{cur_vy[7]}}, cur_vy};
      nvy  = cur_vy - 8'sd1;
    end

    x_sum = {1'b0, cur_x} + X_SPD;
    if (cur_dir) begin
      edge_hit = (x_sum >= X_LIM);
      nx       = edge_hit ? X_LIM[9:0] : x_sum[9:0];
      ndir     = !edge_hit;
    end else begin
      edge_hit = ({1'b0, cur_x} <= X_SPD);
      nx       = ({1'b0, cur_x} < X_SPD) ? 10'd0 : cur_x - X_SPD[9:0];
      ndir     = edge_hit;
    end

    if (ground || edge_hit)      nglow = GLOW_HIT;
    else if (cur_glow > GLOW_MIN) nglow = cur_glow - GLOW_STEP;
    else                          nglow = cur_glow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_reg[i]    <= 10'(i * (FIELD_W / NUM_BALLS));
        alt_reg[i]  <= '0;
        vy_reg[i]   <= 8'(INIT_VEL - 2 * i);
        dir_reg[i]  <= (i % 2 == 0);
        glow_reg[i] <= GLOW_INIT;
      end
      acc_reg      <= 1'b0;
      bounce_pulse <= 1'b0;
    end else begin
      bounce_pulse <= 1'b0;
      if (state_reg == UPDATE) begin
        x_reg[idx_reg]    <= nx;
        alt_reg[idx_reg]  <= nalt;
        vy_reg[idx_reg]   <= nvy;
        dir_reg[idx_reg]  <= ndir;
        glow_reg[idx_reg] <= nglow;
        // One pulse per update pass, however many balls bounced.
        if (idx_reg == LAST) begin
          bounce_pulse <= acc_reg | ground | edge_hit;
          acc_reg      <= 1'b0;
        end else begin
          acc_reg <= acc_reg | ground | edge_hit;
        end
      end
`ifdef BOUNCE_SPRITES_COLLIDE_EN
      if (state_reg == COLLIDE && pair_hit) begin
        dir_reg[pi_reg]  <= ~dir_reg[pi_reg];
        dir_reg[pj_reg]  <= ~dir_reg[pj_reg];
        glow_reg[pi_reg] <= GLOW_HIT;
        glow_reg[pj_reg] <= GLOW_HIT;
      end
`endif
    end
  end

  logic [NUM_BALLS-1:0] heart_vec, ring_vec;
  logic [5:0]           rgb_next;
  logic                 hit_next;

  generate
    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_render
      ball_render #(.RADIUS(RADIUS), .GROUND_Y(GROUND_Y)) u_render (
        .h     (h),
        .v     (v),
        .x     (x_reg[gi]),
        .alt   (alt_reg[gi]),
        .glow  (glow_reg[gi]),
        .heart (heart_vec[gi]),
        .ring  (ring_vec[gi])
      );
    end
  endgenerate

  // Scan from the highest index down so the lowest-index ball ends on top.
  always_comb begin
    rgb_next = 6'd0;
    hit_next = 1'b0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (heart_vec[i]) begin
        rgb_next = COLOR_HEART;
        hit_next = 1'b1;
      end else if (ring_vec[i]) begin
        rgb_next = COLOR_RING;
        hit_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= 6'd0;
      hit <= 1'b0;
    end else begin
      rgb <= rgb_next;
      hit <= hit_next;
    end
  end

endmodule

// File: tb/tb_bounce_sprites.sv
// Self-checking bench for bounce_sprites: pixel scoreboard with a decoupled
// monitor, plus per-frame busy/bounce checks against hand-computed trajectories.
module tb_bounce_sprites;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h, v;
  logic       frame_end;
  logic [5:0] rgb;
  logic       hit, busy, bounce_pulse;

  int n_checks = 0;
  int n_errors = 0;

`ifdef BOUNCE_SPRITES_COLLIDE_EN
  localparam int BUSY_LEN = 6;
`else
  localparam int BUSY_LEN = 3;
`endif

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hit;
    logic [5:0] rgb;
  } pix_t;

  pix_t sb_q[$];
  pix_t exp_e;
  logic pix_vld   = 1'b0;
  logic pix_vld_d = 1'b0;

  bounce_sprites dut (
    .clk          (clk),
    .reset        (reset),
    .h            (h),
    .v            (v),
    .frame_end    (frame_end),
    .rgb          (rgb),
    .hit          (hit),
    .busy         (busy),
    .bounce_pulse (bounce_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pix_vld_d <= pix_vld;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expected pixel whenever a driven pixel has had its clock.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_vld_d) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL pix_queue: output seen with no expected entry");
        end else begin
          exp_e = sb_q.pop_front();
          if (hit !== exp_e.hit || rgb !== exp_e.rgb) begin
            n_errors++;
            $display("FAIL pix(%0d,%0d): got hit=%0b rgb=%06b expected hit=%0b rgb=%06b",
                     exp_e.h, exp_e.v, hit, rgb, exp_e.hit, exp_e.rgb);
          end else begin
            $display("pix(%0d,%0d): hit=%0b rgb=%06b ok", exp_e.h, exp_e.v, hit, rgb);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ball(input int i, input int ex, input int ea, input int evy,
                          input int ed, input int eg);
    chk($sformatf("b%0d_x", i),    int'(dut.x_reg[i]),    ex);
    chk($sformatf("b%0d_alt", i),  int'(dut.alt_reg[i]),  ea);
    chk($sformatf("b%0d_vy", i),   int'(dut.vy_reg[i]),   evy);
    chk($sformatf("b%0d_dir", i),  int'(dut.dir_reg[i]),  ed);
    chk($sformatf("b%0d_glow", i), int'(dut.glow_reg[i]), eg);
  endtask

  task automatic pix(input int hh, input int vv, input bit eh, input logic [5:0] er);
    pix_t e;
    @(negedge clk);
    h = 10'(hh);
    v = 10'(vv);
    e.h = 10'(hh); e.v = 10'(vv); e.hit = eh; e.rgb = er;
    sb_q.push_back(e);
    pix_vld = 1'b1;
    @(negedge clk);
    pix_vld = 1'b0;
    h = 10'd700;
    v = 10'd500;
  endtask

  // Fixed observation window per frame; counts busy and pulse cycles.
  task automatic run_frame(input int len, output int bc, output int pc);
    bc = 0;
    pc = 0;
    @(negedge clk);
    frame_end = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == len - 1) frame_end = 1'b0;
      if (busy) bc++;
      if (bounce_pulse) pc++;
    end
  endtask

  localparam logic [5:0] HEART = 6'b11_00_00;
  localparam logic [5:0] RING  = 6'b10_00_00;
  localparam logic [5:0] NONE  = 6'b00_00_00;

  int bc, pc;

  initial begin
    reset = 1'b1;
    h = 10'd700;
    v = 10'd500;
    frame_end = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_pulse", int'(bounce_pulse), 0);
    chk_ball(0, 0, 0, 21, 1, 10);
    chk_ball(1, 213, 0, 19, 0, 10);
    chk_ball(2, 426, 0, 17, 1, 10);

    pix(16, 368, 1'b1, HEART);
    pix(16, 358, 1'b1, RING);
    pix(0, 352, 1'b0, NONE);
    pix(100, 352, 1'b0, NONE);
    pix(229, 368, 1'b1, HEART);
    pix(244, 368, 1'b1, RING);
    pix(245, 368, 1'b0, NONE);
    pix(16, 351, 1'b0, NONE);

    run_frame(1, bc, pc);
    $display("frame 1: busy=%0d pulses=%0d", bc, pc);
    chk("f1_busy", bc, BUSY_LEN);
    chk("f1_pulse", pc, 0);
    chk_ball(0, 2, 21, 20, 1, 10);
    chk_ball(1, 211, 19, 18, 0, 10);
    chk_ball(2, 428, 17, 16, 1, 10);

    pix(18, 347, 1'b1, HEART);
    pix(18, 340, 1'b1, RING);
    pix(18, 330, 1'b0, NONE);
    pix(18, 332, 1'b1, RING);
    pix(33, 347, 1'b1, RING);
    pix(34, 347, 1'b0, NONE);

    // Second frame_end cycle lands in UPDATE and must be ignored.
    run_frame(2, bc, pc);
    $display("frame 2: busy=%0d pulses=%0d", bc, pc);
    chk("f2_busy", bc, BUSY_LEN);
    chk("f2_pulse", pc, 0);
    chk_ball(0, 4, 41, 19, 1, 10);

    for (int f = 3; f <= 107; f++) begin
      run_frame(1, bc, pc);
      $display("frame %0d: busy=%0d pulses=%0d", f, bc, pc);
      chk($sformatf("f%0d_busy", f), bc, BUSY_LEN);
      chk($sformatf("f%0d_pulse", f), pc,
          int'(f inside {35, 39, 43, 76, 82, 86, 91, 107}));
      if (f == 43) begin
        chk_ball(0, 86, 0, 21, 1, 200);
        chk_ball(1, 127, 66, 14, 0, 160);
        chk_ball(2, 512, 156, 15, 1, 120);
        pix(102, 368, 1'b1, HEART);
        pix(102, 358, 1'b1, HEART);
        pix(102, 354, 1'b1, HEART);
        pix(102, 353, 1'b1, RING);
      end
      if (f == 91) chk_ball(2, 608, 153, 12, 0, 200);
      if (f == 107) chk_ball(1, 0, 279, -7, 1, 200);
    end

    // Reset while an update is in flight.
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_pulse", int'(bounce_pulse), 0);
    chk("abort_hit", int'(hit), 0);
    chk_ball(0, 0, 0, 21, 1, 10);
    chk_ball(1, 213, 0, 19, 0, 10);
    chk_ball(2, 426, 0, 17, 1, 10);
    repeat (6) @(negedge clk);
    chk("abort_idle", int'(busy), 0);

    pix(16, 368, 1'b1, HEART);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
